// File: rtl/cache_fsm_l2c.sv
// Direct-mapped, write-back, write-allocate L2 controller behind the L1 cache FSM.
// Serves L1 line reads, word write-throughs and dirty-line write-backs; fetches/evicts over a mem handshake.
module cache_fsm_l2c #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int NUM_SETS      = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cache_L2_memory_address,
  input  logic                     read_from_L2_request,
  input  logic                     write_to_L2_request,
  input  logic                     write_back_to_L2_request,
  input  logic [DATA_WIDTH-1:0]    cache_write_data,
  input  logic [LINE_WIDTH-1:0]    write_back_to_L2_data,
  output logic [LINE_WIDTH-1:0]    write_data_to_L1_from_L2,
  output logic                     L2_ready,
  output logic                     write_to_L2_verified,
  output logic                     write_back_to_L2_verified,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_read_request,
  output logic                     mem_write_request,
  output logic [LINE_WIDTH-1:0]    mem_write_data,
  input  logic [LINE_WIDTH-1:0]    mem_read_data,
  input  logic                     mem_ready,
  output logic [COUNT_WIDTH-1:0]   L2_hit_count,
  output logic [COUNT_WIDTH-1:0]   L2_miss_count
);

  localparam int WORDS   = LINE_WIDTH / DATA_WIDTH;
  localparam int OFF     = $clog2(WORDS);
  localparam int IDX     = $clog2(NUM_SETS);
  localparam int LSB_IDX = OFF + 2;
  localparam int LSB_TAG = OFF + IDX + 2;
  localparam int TAG_W   = ADDRESS_WIDTH - LSB_TAG;

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_EVICT, S_FETCH, S_RESPOND} state_t;
  typedef enum logic [1:0] {REQ_RD, REQ_WR, REQ_WB} req_t;

  state_t                   r_state, w_next_state;
  req_t                     r_req;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_word;
  logic [LINE_WIDTH-1:0]    r_line;
  logic                     r_retry;

  logic [NUM_SETS-1:0]      r_valid, r_dirty;
  logic [TAG_W-1:0]         r_tag  [NUM_SETS];
  logic [LINE_WIDTH-1:0]    r_data [NUM_SETS];

  logic [OFF-1:0]           w_offset;
  logic [IDX-1:0]           w_index;
  logic [TAG_W-1:0]         w_tag;
  logic                     w_hit, w_victim_dirty, w_accept;
  logic [LINE_WIDTH-1:0]    w_merged, w_line_in;
  logic                     w_line_we, w_tag_we, w_valid_set, w_dirty_we, w_dirty_val, w_l1_load;

  assign w_offset       = r_addr[OFF+1:2];
  assign w_index        = r_addr[LSB_TAG-1:LSB_IDX];
  assign w_tag          = r_addr[ADDRESS_WIDTH-1:LSB_TAG];
  assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
  assign w_accept       = read_from_L2_request || write_to_L2_request || write_back_to_L2_request;

  always_comb begin
    w_merged = r_data[w_index];
    w_merged[w_offset*DATA_WIDTH +: DATA_WIDTH] = r_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_line_we    = 1'b0;
    w_line_in    = r_line;
    w_tag_we     = 1'b0;
    w_valid_set  = 1'b0;
    w_dirty_we   = 1'b0;
    w_dirty_val  = 1'b0;
    w_l1_load    = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_COMPARE;
      S_COMPARE: begin
        if (w_hit) begin
          w_next_state = S_RESPOND;
          case (r_req)
            REQ_RD: w_l1_load = 1'b1;
            REQ_WR: begin
              w_line_we   = 1'b1;
              w_line_in   = w_merged;
              w_dirty_we  = 1'b1;
              w_dirty_val = 1'b1;
            end
            default: begin
              w_line_we   = 1'b1;
              w_dirty_we  = 1'b1;
              w_dirty_val = 1'b1;
            end
          endcase
        end else if (w_victim_dirty) begin
          w_next_state = S_EVICT;
        end else if (r_req == REQ_WB) begin
          // A full line from L1 needs no fill from memory.
          w_next_state = S_RESPOND;
          w_line_we    = 1'b1;
          w_tag_we     = 1'b1;
          w_valid_set  = 1'b1;
          w_dirty_we   = 1'b1;
          w_dirty_val  = 1'b1;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_EVICT: if (mem_ready) begin
        w_dirty_we = 1'b1;
        if (r_req == REQ_WB) begin
          w_next_state = S_RESPOND;
          w_line_we    = 1'b1;
          w_tag_we     = 1'b1;
          w_valid_set  = 1'b1;
          w_dirty_val  = 1'b1;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: if (mem_ready) begin
        w_next_state = S_COMPARE;
        w_line_we    = 1'b1;
        w_line_in    = mem_read_data;
        w_tag_we     = 1'b1;
        w_valid_set  = 1'b1;
        w_dirty_we   = 1'b1;
      end
      S_RESPOND: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // NOTE: line data and tags are not reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (w_line_we) r_data[w_index] <= w_line_in;
    if (w_tag_we)  r_tag[w_index]  <= w_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req                     <= REQ_RD;
      r_addr                    <= '0;
      r_word                    <= '0;
      r_line                    <= '0;
      r_retry                   <= 1'b0;
      r_valid                   <= '0;
      r_dirty                   <= '0;
      L2_hit_count              <= '0;
      L2_miss_count             <= '0;
      L2_ready                  <= 1'b0;
      write_to_L2_verified      <= 1'b0;
      write_back_to_L2_verified <= 1'b0;
      mem_read_request          <= 1'b0;
      mem_write_request         <= 1'b0;
      mem_address               <= '0;
      mem_write_data            <= '0;
      write_data_to_L1_from_L2  <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_addr  <= cache_L2_memory_address;
        r_word  <= cache_write_data;
        r_line  <= write_back_to_L2_data;
        r_retry <= 1'b0;
        if (write_back_to_L2_request) r_req <= REQ_WB;
        else if (write_to_L2_request) r_req <= REQ_WR;
        else                          r_req <= REQ_RD;
      end
      if (r_state == S_FETCH && mem_ready) r_retry <= 1'b1;
      if (w_valid_set) r_valid[w_index] <= 1'b1;
      if (w_dirty_we)  r_dirty[w_index] <= w_dirty_val;

      // The hit after a fill belongs to the miss that caused it.
      if (r_state == S_COMPARE) begin
        if (w_hit) begin
          if (!r_retry && L2_hit_count != '1) L2_hit_count <= L2_hit_count + COUNT_WIDTH'(1);
        end else if (L2_miss_count != '1) begin
          L2_miss_count <= L2_miss_count + COUNT_WIDTH'(1);
        end
      end

      if (w_l1_load) write_data_to_L1_from_L2 <= r_data[w_index];
      L2_ready                  <= (w_next_state == S_RESPOND) && (r_req == REQ_RD);
      write_to_L2_verified      <= (w_next_state == S_RESPOND) && (r_req == REQ_WR);
      write_back_to_L2_verified <= (w_next_state == S_RESPOND) && (r_req == REQ_WB);
      mem_read_request          <= (w_next_state == S_FETCH);
      mem_write_request         <= (w_next_state == S_EVICT);

      if (r_state == S_COMPARE && w_next_state == S_EVICT) begin
        mem_address    <= {r_tag[w_index], w_index, {LSB_IDX{1'b0}}};
        mem_write_data <= r_data[w_index];
      end else if (r_state != S_FETCH && w_next_state == S_FETCH) begin
        mem_address    <= {w_tag, w_index, {LSB_IDX{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_cache_fsm_l2c.sv
// Scoreboard bench for cache_fsm_l2c: stimulus queues expected L1 responses and memory transactions,
// separate monitors pop and compare them as the DUT presents pulses and memory requests.
module tb_cache_fsm_l2c;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  cache_L2_memory_address;
  logic         read_from_L2_request, write_to_L2_request, write_back_to_L2_request;
  logic [31:0]  cache_write_data;
  logic [127:0] write_back_to_L2_data;
  logic [127:0] write_data_to_L1_from_L2;
  logic         L2_ready, write_to_L2_verified, write_back_to_L2_verified;
  logic [31:0]  mem_address;
  logic         mem_read_request, mem_write_request;
  logic [127:0] mem_write_data, mem_read_data;
  logic         mem_ready;
  logic [3:0]   L2_hit_count, L2_miss_count;

  cache_fsm_l2c #(.COUNT_WIDTH(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .cache_L2_memory_address  (cache_L2_memory_address),
    .read_from_L2_request     (read_from_L2_request),
    .write_to_L2_request      (write_to_L2_request),
    .write_back_to_L2_request (write_back_to_L2_request),
    .cache_write_data         (cache_write_data),
    .write_back_to_L2_data    (write_back_to_L2_data),
    .write_data_to_L1_from_L2 (write_data_to_L1_from_L2),
    .L2_ready                 (L2_ready),
    .write_to_L2_verified     (write_to_L2_verified),
    .write_back_to_L2_verified(write_back_to_L2_verified),
    .mem_address              (mem_address),
    .mem_read_request         (mem_read_request),
    .mem_write_request        (mem_write_request),
    .mem_write_data           (mem_write_data),
    .mem_read_data            (mem_read_data),
    .mem_ready                (mem_ready),
    .L2_hit_count             (L2_hit_count),
    .L2_miss_count            (L2_miss_count)
  );

  always #5 clk = ~clk;

  localparam int K_RD = 0, K_WR = 1, K_WB = 2;

  typedef struct {
    int           kind;
    logic [127:0] line;
    bit           lat;
    int           cyc;
  } resp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] data;
  } mem_t;

  resp_t        exp_resp[$];
  mem_t         exp_mem[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [127:0] fetch_line;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (L2_ready || write_to_L2_verified || write_back_to_L2_verified) begin
        int    act_kind;
        resp_t e;
        act_kind = write_back_to_L2_verified ? K_WB : (write_to_L2_verified ? K_WR : K_RD);
        check("one_pulse", 128'(L2_ready) + 128'(write_to_L2_verified) + 128'(write_back_to_L2_verified), 1);
        check("resp_expected", 128'(exp_resp.size() != 0), 1);
        if (exp_resp.size() != 0) begin
          e = exp_resp.pop_front();
          check("resp_kind", act_kind, e.kind);
          if (e.kind == K_RD) check("resp_line", write_data_to_L1_from_L2, e.line);
          if (e.lat) check("hit_latency", cyc - e.cyc, 2);
        end
      end
    end
  end

  // Memory model and memory-side monitor: mem_ready three cycles after the request appears.
  initial begin
    mem_ready     = 1'b0;
    mem_read_data = '0;
    forever begin
      @(negedge clk);
      if (reset && (mem_read_request || mem_write_request)) begin
        mem_t e;
        check("mem_exclusive", 128'(mem_read_request & mem_write_request), 0);
        check("mem_expected", 128'(exp_mem.size() != 0), 1);
        if (exp_mem.size() != 0) begin
          e = exp_mem.pop_front();
          check("mem_is_write", 128'(mem_write_request), 128'(e.wr));
          check("mem_addr", mem_address, e.addr);
          if (e.wr) check("mem_wdata", mem_write_data, e.data);
        end
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b1;
        mem_read_data = fetch_line;
        @(posedge clk);
        #1 mem_ready = 1'b0;
      end
    end
  end

  task automatic wait_pulse(input int kind);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((kind == K_RD && L2_ready) || (kind == K_WR && write_to_L2_verified) ||
          (kind == K_WB && write_back_to_L2_verified)) got = 1'b1;
    end
    check("pulse_within_budget", 128'(got), 1);
  endtask

  task automatic expect_mem(input bit wr, input logic [31:0] addr, input logic [127:0] data);
    mem_t m;
    m.wr = wr; m.addr = addr; m.data = data;
    exp_mem.push_back(m);
  endtask

  task automatic expect_resp(input int kind, input logic [127:0] line, input bit lat);
    resp_t r;
    r.kind = kind; r.line = line; r.lat = lat; r.cyc = cyc;
    exp_resp.push_back(r);
  endtask

  // Called just after a rising edge; returns just after a rising edge with the request dropped.
  task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] word,
                       input logic [127:0] line, input logic [127:0] exp_line, input bit lat);
    expect_resp(kind, exp_line, lat);
    cache_L2_memory_address = addr;
    cache_write_data        = word;
    write_back_to_L2_data   = line;
    read_from_L2_request     = (kind == K_RD);
    write_to_L2_request      = (kind == K_WR);
    write_back_to_L2_request = (kind == K_WB);
    wait_pulse(kind);
    @(posedge clk);
    #1;
    read_from_L2_request     = 1'b0;
    write_to_L2_request      = 1'b0;
    write_back_to_L2_request = 1'b0;
  endtask

  localparam logic [127:0] LA  = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] LB  = {4{32'hBBBB_BBBB}};
  localparam logic [127:0] LC  = {32'h0C0C_0004, 32'h0C0C_0003, 32'h0C0C_0002, 32'h0C0C_0001};
  localparam logic [127:0] LD  = {4{32'hD00D_F00D}};
  localparam logic [127:0] LAW = {32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 32'hAAAA_AAAA};

  initial begin
    bit saw_req;
    reset                    = 1'b0;
    cache_L2_memory_address  = '0;
    read_from_L2_request     = 1'b0;
    write_to_L2_request      = 1'b0;
    write_back_to_L2_request = 1'b0;
    cache_write_data         = '0;
    write_back_to_L2_data    = '0;
    fetch_line               = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hit", L2_hit_count, 0);
    check("rst_miss", L2_miss_count, 0);
    check("rst_pulses", {L2_ready, write_to_L2_verified, write_back_to_L2_verified}, 0);
    check("rst_mem_req", {mem_read_request, mem_write_request}, 0);
    check("rst_mem_addr", mem_address, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Cold read: one fill, one miss.
    fetch_line = LA;
    expect_mem(1'b0, 32'h8000_0010, '0);
    issue(K_RD, 32'h8000_0010, '0, '0, LA, 1'b0);
    check("cold_miss", L2_miss_count, 1);
    check("cold_hit", L2_hit_count, 0);

    // Repeat read hits in two cycles.
    issue(K_RD, 32'h8000_0010, '0, '0, LA, 1'b1);
    check("warm_hit", L2_hit_count, 1);

    // Word write to word 1 of set 1, then read it back.
    issue(K_WR, 32'h8000_0014, 32'hDEAD_BEEF, '0, '0, 1'b1);
    issue(K_RD, 32'h8000_0014, '0, '0, LAW, 1'b1);
    check("after_write_hit", L2_hit_count, 3);

    // Conflict read evicts the dirty line then fills.
    fetch_line = LB;
    expect_mem(1'b1, 32'h8000_0010, LAW);
    expect_mem(1'b0, 32'h8000_1010, '0);
    issue(K_RD, 32'h8000_1010, '0, '0, LB, 1'b0);
    check("conflict_hit", L2_hit_count, 3);
    check("conflict_miss", L2_miss_count, 2);

    // Write-back and read together: write-back first, read then hits the written line.
    expect_resp(K_WB, '0, 1'b0);
    expect_resp(K_RD, LC, 1'b0);
    cache_L2_memory_address  = 32'h8000_0020;
    write_back_to_L2_data    = LC;
    write_back_to_L2_request = 1'b1;
    read_from_L2_request     = 1'b1;
    wait_pulse(K_WB);
    @(posedge clk);
    #1 write_back_to_L2_request = 1'b0;
    wait_pulse(K_RD);
    @(posedge clk);
    #1 read_from_L2_request = 1'b0;
    check("wb_rd_miss", L2_miss_count, 3);
    check("wb_rd_hit", L2_hit_count, 4);

    // Reset during a fill drops the memory request at once.
    fetch_line = LD;
    expect_mem(1'b0, 32'h8000_0030, '0);
    cache_L2_memory_address = 32'h8000_0030;
    read_from_L2_request    = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 20 && !saw_req; i++) begin
      @(negedge clk);
      if (mem_read_request) saw_req = 1'b1;
    end
    check("fetch_started", 128'(saw_req), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_drops_mem_read", 128'(mem_read_request), 0);
    check("rst_clears_miss", L2_miss_count, 0);
    read_from_L2_request = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    expect_mem(1'b0, 32'h8000_0030, '0);
    issue(K_RD, 32'h8000_0030, '0, '0, LD, 1'b0);
    check("post_rst_miss", L2_miss_count, 1);
    check("post_rst_hit", L2_hit_count, 0);

    // Hit counter saturates at all-ones (4-bit counter here).
    for (int k = 1; k <= 17; k++) begin
      issue(K_RD, 32'h8000_0030, '0, '0, LD, 1'b1);
      check("hit_saturate", L2_hit_count, (k > 15) ? 15 : k);
    end
    check("sat_miss_unchanged", L2_miss_count, 1);

    repeat (5) @(posedge clk);
    check("resp_queue_drained", exp_resp.size(), 0);
    check("mem_queue_drained", exp_mem.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
